hdmi_data_island_receiver: RTL and testbench

HDMI_DATA_ISLAND_RECEIVER -- requirements
Module: hdmi_data_island_receiver

---
 rtl/hdmi_data_island_receiver.sv | 207 ++++++++++++++++++++
 tb/tb_hdmi_data_island_receiver.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_data_island_receiver.sv
// HDMI data island receiver: TERC4 decode, guard-band framing, 32-symbol packet
// assembly into shadow registers, per-packet error flag and InfoFrame checksum.
module hdmi_data_island_receiver #(
    parameter int unsigned MAX_PACKETS = 18
) (
    input  logic        clk_pixel,
    input  logic        reset_n,
    input  logic [9:0]  tmds_ch0,
    input  logic [9:0]  tmds_ch1,
    input  logic [9:0]  tmds_ch2,
    output logic        packet_valid,
    output logic [31:0] header,
    output logic [63:0] sub0,
    output logic [63:0] sub1,
    output logic [63:0] sub2,
    output logic [63:0] sub3,
    output logic        packet_error,
    output logic        checksum_ok,
    output logic        island_error
);

    typedef enum logic [1:0] {IDLE, LEAD, PAYLOAD, TRAIL} state_t;

    localparam logic [9:0] GB_CODE = 10'b0100110011;

    // Returns {valid, nibble}; codes outside the table decode to 0 and invalid.
    function automatic logic [4:0] terc4_decode(input logic [9:0] sym);
        case (sym)
            10'b1010011100: terc4_decode = 5'h10;
            10'b1001100011: terc4_decode = 5'h11;
            10'b1011100100: terc4_decode = 5'h12;
            10'b1011100010: terc4_decode = 5'h13;
            10'b0101110001: terc4_decode = 5'h14;
            10'b0100011110: terc4_decode = 5'h15;
            10'b0110001110: terc4_decode = 5'h16;
            10'b0100111100: terc4_decode = 5'h17;
            10'b1011001100: terc4_decode = 5'h18;
            10'b0100111001: terc4_decode = 5'h19;
            10'b0110011100: terc4_decode = 5'h1A;
            10'b1011000110: terc4_decode = 5'h1B;
            10'b1010001110: terc4_decode = 5'h1C;
            10'b1001110001: terc4_decode = 5'h1D;
            10'b0101100011: terc4_decode = 5'h1E;
            10'b1011000011: terc4_decode = 5'h1F;
            default:        terc4_decode = 5'h00;
        endcase
    endfunction

    function automatic logic [7:0] byte_sum7(input logic [55:0] s);
        byte_sum7 = s[7:0] + s[15:8] + s[23:16] + s[31:24] + s[39:32] + s[47:40] + s[55:48];
    endfunction

    logic [4:0] dec0, dec1, dec2;
    logic [3:0] d0, d1, d2;
    logic       v0, v1, v2;
    logic       is_gb;

    assign dec0 = terc4_decode(tmds_ch0);
    assign dec1 = terc4_decode(tmds_ch1);
    assign dec2 = terc4_decode(tmds_ch2);
    assign {v0, d0} = dec0;
    assign {v1, d1} = dec1;
    assign {v2, d2} = dec2;
    assign is_gb = (tmds_ch1 == GB_CODE) && (tmds_ch2 == GB_CODE) && v0 && (d0 >= 4'hC);

    state_t     state, state_next;
    logic [4:0] sym_cnt, pkt_cnt;
    logic       after_pkt, pkt_full;
    logic       capture, complete, island_err_set;

    // First symbol following a completed packet: either trailing guard band or next packet.
    assign after_pkt = (state == PAYLOAD) && (sym_cnt == '0) && (pkt_cnt != '0);
    assign pkt_full  = {27'd0, pkt_cnt} >= MAX_PACKETS;

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (is_gb) state_next = LEAD;
            LEAD:    state_next = is_gb ? PAYLOAD : IDLE;
            PAYLOAD: begin
                if (after_pkt) begin
                    if (is_gb)         state_next = TRAIL;
                    else if (pkt_full) state_next = IDLE;
                end
            end
            TRAIL:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        capture        = 1'b0;
        complete       = 1'b0;
        island_err_set = 1'b0;
        case (state)
            PAYLOAD: begin
                if (!after_pkt) begin
                    capture  = 1'b1;
                    complete = (sym_cnt == 5'd31);
                end else if (!is_gb) begin
                    if (pkt_full) island_err_set = 1'b1;
                    else          capture        = 1'b1;
                end
            end
            TRAIL:   island_err_set = !is_gb;
            default: ;
        endcase
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            sym_cnt <= '0;
            pkt_cnt <= '0;
        end else begin
            if (state == LEAD && is_gb) sym_cnt <= '0;
            else if (capture)           sym_cnt <= sym_cnt + 5'd1;

            if (state == IDLE && is_gb)           pkt_cnt <= '0;
            else if (complete && pkt_cnt != '1)   pkt_cnt <= pkt_cnt + 5'd1;
        end
    end

    logic [31:0] hdr_sh, hdr_nx;
    logic [63:0] s0_sh, s1_sh, s2_sh, s3_sh;
    logic [63:0] s0_nx, s1_nx, s2_nx, s3_nx;
    logic        err_sh, err_nx;
    logic [7:0]  csum;
    logic        cks_nx;

    // Next-shadow view merges the current symbol so completion can publish symbol 31 directly.
    always_comb begin
        hdr_nx = hdr_sh;
        s0_nx  = s0_sh;
        s1_nx  = s1_sh;
        s2_nx  = s2_sh;
        s3_nx  = s3_sh;
        err_nx = err_sh;
        if (capture) begin
            hdr_nx[sym_cnt]          = d0[2];
            s0_nx[{sym_cnt, 1'b0}]   = d1[0];
            s1_nx[{sym_cnt, 1'b0}]   = d1[1];
            s2_nx[{sym_cnt, 1'b0}]   = d1[2];
            s3_nx[{sym_cnt, 1'b0}]   = d1[3];
            s0_nx[{sym_cnt, 1'b1}]   = d2[0];
            s1_nx[{sym_cnt, 1'b1}]   = d2[1];
            s2_nx[{sym_cnt, 1'b1}]   = d2[2];
            s3_nx[{sym_cnt, 1'b1}]   = d2[3];
            err_nx = ((sym_cnt == '0) ? 1'b0 : err_sh) | !v0 | !v1 | !v2
                   | (d0[3] != (sym_cnt != '0));
        end
    end

    assign csum = hdr_nx[7:0] + hdr_nx[15:8] + hdr_nx[23:16]
                + byte_sum7(s0_nx[55:0]) + byte_sum7(s1_nx[55:0])
                + byte_sum7(s2_nx[55:0]) + byte_sum7(s3_nx[55:0]);
    assign cks_nx = !hdr_nx[7] || (csum == 8'h00);

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            hdr_sh <= '0;
            s0_sh  <= '0;
            s1_sh  <= '0;
            s2_sh  <= '0;
            s3_sh  <= '0;
            err_sh <= 1'b0;
        end else begin
            hdr_sh <= hdr_nx;
            s0_sh  <= s0_nx;
            s1_sh  <= s1_nx;
            s2_sh  <= s2_nx;
            s3_sh  <= s3_nx;
            err_sh <= err_nx;
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            packet_valid <= 1'b0;
            island_error <= 1'b0;
            header       <= '0;
            sub0         <= '0;
            sub1         <= '0;
            sub2         <= '0;
            sub3         <= '0;
            packet_error <= 1'b0;
            checksum_ok  <= 1'b0;
        end else begin
            packet_valid <= complete;
            island_error <= island_err_set;
            if (complete) begin
                header       <= hdr_nx;
                sub0         <= s0_nx;
                sub1         <= s1_nx;
                sub2         <= s2_nx;
                sub3         <= s3_nx;
                packet_error <= err_nx;
                checksum_ok  <= cks_nx;
            end
        end
    end

endmodule

// File: tb/tb_hdmi_data_island_receiver.sv
// Bench for hdmi_data_island_receiver: packets are built as header/subpacket bits,
// TERC4-encoded per symbol, and the decoded outputs compared with the intended packet.
module tb_hdmi_data_island_receiver;

    localparam logic [9:0] GB = 10'b0100110011;

    logic        clk_pixel = 1'b0;
    logic        reset_n   = 1'b0;
    logic [9:0]  tmds_ch0, tmds_ch1, tmds_ch2;
    logic        packet_valid, packet_error, checksum_ok, island_error;
    logic [31:0] header;
    logic [63:0] sub0, sub1, sub2, sub3;
    logic        pv2, pe2, ck2, ie2;
    logic [31:0] hdr2;
    logic [63:0] s20, s21, s22, s23;

    hdmi_data_island_receiver dut (
        .clk_pixel(clk_pixel), .reset_n(reset_n),
        .tmds_ch0(tmds_ch0), .tmds_ch1(tmds_ch1), .tmds_ch2(tmds_ch2),
        .packet_valid(packet_valid), .header(header),
        .sub0(sub0), .sub1(sub1), .sub2(sub2), .sub3(sub3),
        .packet_error(packet_error), .checksum_ok(checksum_ok), .island_error(island_error)
    );

    hdmi_data_island_receiver #(.MAX_PACKETS(2)) dut2 (
        .clk_pixel(clk_pixel), .reset_n(reset_n),
        .tmds_ch0(tmds_ch0), .tmds_ch1(tmds_ch1), .tmds_ch2(tmds_ch2),
        .packet_valid(pv2), .header(hdr2),
        .sub0(s20), .sub1(s21), .sub2(s22), .sub3(s23),
        .packet_error(pe2), .checksum_ok(ck2), .island_error(ie2)
    );

    always #5 clk_pixel = ~clk_pixel;

    typedef struct packed {
        logic [31:0]      hdr;
        logic [3:0][63:0] sub;
    } pkt_data_t;

    typedef struct packed {
        pkt_data_t   d;
        logic        err;
        logic        cks;
        logic [31:0] cyc;
    } pkt_t;

    logic [9:0] terc4 [16];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   ie_cnt   = 0;
    int   ie2_cnt  = 0;
    int   ie2_cyc  = 0;
    pkt_t obs_q[$], obs2_q[$], exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One symbol per clock; outputs sampled 1 time unit after the edge.
    task automatic send(input logic [9:0] c0, input logic [9:0] c1, input logic [9:0] c2);
        pkt_t o;
        tmds_ch0 = c0;
        tmds_ch1 = c1;
        tmds_ch2 = c2;
        cyc++;
        @(posedge clk_pixel);
        #1;
        if (packet_valid === 1'b1) begin
            o.d.hdr = header;
            o.d.sub = {sub3, sub2, sub1, sub0};
            o.err   = packet_error;
            o.cks   = checksum_ok;
            o.cyc   = cyc;
            obs_q.push_back(o);
        end
        if (pv2 === 1'b1) begin
            o.d.hdr = hdr2;
            o.d.sub = {s23, s22, s21, s20};
            o.err   = pe2;
            o.cks   = ck2;
            o.cyc   = cyc;
            obs2_q.push_back(o);
        end
        if (island_error === 1'b1) ie_cnt++;
        if (ie2 === 1'b1) begin
            ie2_cnt++;
            ie2_cyc = cyc;
        end
    endtask

    task automatic gb();
        send(terc4[4'hC + 4'($urandom_range(0, 3))], GB, GB);
    endtask

    task automatic filler();
        send(terc4[4'($urandom())], terc4[4'($urandom())], terc4[4'($urandom())]);
    endtask

    function automatic logic [7:0] pb_sum(input pkt_data_t d);
        logic [7:0] s;
        s = d.hdr[7:0] + d.hdr[15:8] + d.hdr[23:16];
        for (int i = 0; i < 28; i++) s = s + d.sub[i / 7][8 * (i % 7) +: 8];
        return s;
    endfunction

    function automatic pkt_data_t rand_pkt();
        pkt_data_t p;
        p.hdr = $urandom();
        for (int k = 0; k < 4; k++) p.sub[k] = {$urandom(), $urandom()};
        if ($urandom_range(0, 1) == 1) begin
            p.hdr[7]      = 1'b1;
            p.sub[0][7:0] = 8'h00;
            p.sub[0][7:0] = 8'h00 - pb_sum(p);
        end
        return p;
    endfunction

    // inj: 0 none, 1 bad ch0, 2 bad ch1, 3 bad ch2, 4 ch0 bit 3 flipped.
    task automatic send_packet(input pkt_data_t p, input int inj, input int inj_n,
                               input logic [9:0] bad, input int nsym);
        pkt_t       e;
        logic [3:0] n0, n1, n2;
        logic [9:0] c0, c1, c2;
        e.d   = p;
        e.err = 1'b0;
        e.cks = 1'b0;
        e.cyc = '0;
        for (int n = 0; n < nsym; n++) begin
            n0 = {(n != 0), p.hdr[n], 2'($urandom())};
            for (int k = 0; k < 4; k++) begin
                n1[k] = p.sub[k][2 * n];
                n2[k] = p.sub[k][2 * n + 1];
            end
            c0 = terc4[n0];
            c1 = terc4[n1];
            c2 = terc4[n2];
            if (n == inj_n) begin
                case (inj)
                    1: begin c0 = bad; e.d.hdr[n] = 1'b0; e.err = 1'b1; end
                    2: begin
                        c1 = bad; e.err = 1'b1;
                        for (int k = 0; k < 4; k++) e.d.sub[k][2 * n] = 1'b0;
                    end
                    3: begin
                        c2 = bad; e.err = 1'b1;
                        for (int k = 0; k < 4; k++) e.d.sub[k][2 * n + 1] = 1'b0;
                    end
                    4: begin c0 = terc4[n0 ^ 4'b1000]; e.err = 1'b1; end
                    default: ;
                endcase
            end
            send(c0, c1, c2);
        end
        if (nsym == 32) begin
            e.cks = (e.d.hdr[7] == 1'b0) || (pb_sum(e.d) == 8'h00);
            e.cyc = cyc;
            exp_q.push_back(e);
        end
    endtask

    task automatic check_pkt(input string tag, input pkt_t o, input pkt_t e);
        check({tag, ".header"}, 64'(o.d.hdr), 64'(e.d.hdr));
        for (int k = 0; k < 4; k++)
            check($sformatf("%s.sub%0d", tag, k), o.d.sub[k], e.d.sub[k]);
        check({tag, ".packet_error"}, 64'(o.err), 64'(e.err));
        check({tag, ".checksum_ok"}, 64'(o.cks), 64'(e.cks));
        check({tag, ".latency"}, 64'(o.cyc), 64'(e.cyc));
    endtask

    task automatic verify(input string tag);
        pkt_t o, e;
        check({tag, ".count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check_pkt(tag, o, e);
        end
        obs_q.delete();
        exp_q.delete();
        obs2_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".pv"}, 64'(packet_valid), 64'd0);
        check({tag, ".ie"}, 64'(island_error), 64'd0);
        check({tag, ".pe"}, 64'(packet_error), 64'd0);
        check({tag, ".ck"}, 64'(checksum_ok), 64'd0);
        check({tag, ".header"}, 64'(header), 64'd0);
        check({tag, ".subs"}, 64'(sub0 | sub1 | sub2 | sub3), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, observed still running, required finish");
        $fatal(1);
    end

    initial begin
        pkt_data_t p, q;
        int        ie_base, ie2_base, c_start;

        terc4 = '{10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
                  10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
                  10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
                  10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

        reset_n = 1'b0;
        repeat (3) filler();
        check_all_zero("reset");
        reset_n = 1'b1;
        repeat (2) filler();

        // All-zero packet
        gb(); gb();
        send_packet('0, 0, -1, 10'h000, 32);
        gb(); gb();
        verify("zero");
        check("zero.ie", 64'(ie_cnt), 64'd0);

        // Audio Clock Regeneration: N = 6144, CTS = 25200
        p.hdr = 32'h0000_0001;
        for (int k = 0; k < 4; k++) p.sub[k] = 64'h0000_1800_7062_0000;
        gb(); gb();
        send_packet(p, 0, -1, 10'h000, 32);
        gb(); gb();
        filler();
        check("acr.hold_header", 64'(header[7:0]), 64'h01);
        check("acr.cts", 64'({sub0[11:8], sub0[23:16], sub0[31:24]}), 64'd25200);
        check("acr.n", 64'({sub0[35:32], sub0[47:40], sub0[55:48]}), 64'd6144);
        check("acr.sub_equal", 64'((sub1 == sub0) && (sub2 == sub0) && (sub3 == sub0)), 64'd1);
        verify("acr");

        // AVI InfoFrame, good then corrupted PB1
        p = '0;
        p.hdr = {8'($urandom()), 24'h0D0282};
        for (int i = 1; i < 14; i++) p.sub[i / 7][8 * (i % 7) +: 8] = 8'($urandom());
        p.sub[0][7:0] = 8'h00 - pb_sum(p);
        gb(); gb();
        send_packet(p, 0, -1, 10'h000, 32);
        gb(); gb();
        if (obs_q.size() > 0) check("avi_good.cks", 64'(obs_q[0].cks), 64'd1);
        verify("avi_good");
        q = p;
        q.sub[0][15:8] = q.sub[0][15:8] + 8'h01;
        gb(); gb();
        send_packet(q, 0, -1, 10'h000, 32);
        gb(); gb();
        if (obs_q.size() > 0) check("avi_bad.cks", 64'(obs_q[0].cks), 64'd0);
        verify("avi_bad");

        // Back-to-back packets, second with invalid ch1 at n = 5
        gb(); gb();
        send_packet(rand_pkt(), 0, -1, 10'h000, 32);
        send_packet(rand_pkt(), 2, 5, 10'h000, 32);
        gb(); gb();
        if (obs_q.size() == 2) begin
            check("b2b.spacing", 64'(obs_q[1].cyc - obs_q[0].cyc), 64'd32);
            check("b2b.err0", 64'(obs_q[0].err), 64'd0);
            check("b2b.err1", 64'(obs_q[1].err), 64'd1);
        end
        verify("b2b");

        // Reset at n = 12 discards the partial packet
        gb(); gb();
        send_packet(rand_pkt(), 0, -1, 10'h000, 12);
        reset_n = 1'b0;
        #2;
        check_all_zero("rst_mid");
        @(posedge clk_pixel);
        #1;
        reset_n = 1'b1;
        repeat (20) filler();
        verify("rst_mid");
        check_all_zero("rst_after");
        gb(); gb();
        send_packet(rand_pkt(), 0, -1, 10'h000, 32);
        gb(); gb();
        verify("rst_next");

        // Lead guard band followed by a non-GB symbol: no error, no packet
        ie_base = ie_cnt;
        gb();
        repeat (40) filler();
        verify("lead_abort");
        check("lead_abort.ie", 64'(ie_cnt - ie_base), 64'd0);

        // Single trailing guard band: island error
        ie_base  = ie_cnt;
        ie2_base = ie2_cnt;
        gb(); gb();
        send_packet(rand_pkt(), 0, -1, 10'h000, 32);
        gb();
        filler();
        filler();
        verify("trail_err");
        check("trail_err.ie", 64'(ie_cnt - ie_base), 64'd1);
        check("trail_err.ie2", 64'(ie2_cnt - ie2_base), 64'd1);

        // Three packets without GB: MAX_PACKETS = 2 instance errors out on the third
        ie_base  = ie_cnt;
        ie2_base = ie2_cnt;
        gb(); gb();
        send_packet(rand_pkt(), 0, -1, 10'h000, 32);
        send_packet(rand_pkt(), 0, -1, 10'h000, 32);
        c_start = cyc + 1;
        send_packet(rand_pkt(), 0, -1, 10'h000, 32);
        check("max.pv2_count", 64'(obs2_q.size()), 64'd2);
        check("max.ie2_count", 64'(ie2_cnt - ie2_base), 64'd1);
        check("max.ie2_cycle", 64'(ie2_cyc), 64'(c_start));
        if (obs2_q.size() == 2 && exp_q.size() == 3) begin
            check_pkt("max.dut2_p0", obs2_q[0], exp_q[0]);
            check_pkt("max.dut2_p1", obs2_q[1], exp_q[1]);
        end
        gb(); gb();
        verify("max.dut");
        check("max.ie", 64'(ie_cnt - ie_base), 64'd0);
        reset_n = 1'b0;
        filler();
        reset_n = 1'b1;
        filler();

        // Randomized islands with optional symbol corruption
        for (int it = 0; it < 12; it++) begin
            int np;
            ie_base  = ie_cnt;
            ie2_base = ie2_cnt;
            np = $urandom_range(1, 2);
            gb(); gb();
            for (int j = 0; j < np; j++)
                send_packet(rand_pkt(), $urandom_range(0, 7), $urandom_range(0, 31),
                            ($urandom_range(0, 1) == 1) ? 10'h000 : 10'h3FF, 32);
            gb(); gb();
            repeat (3) filler();
            check($sformatf("rand%0d.pv2_count", it), 64'(obs2_q.size()), 64'(np));
            verify($sformatf("rand%0d", it));
            check($sformatf("rand%0d.ie", it), 64'(ie_cnt - ie_base), 64'd0);
            check($sformatf("rand%0d.ie2", it), 64'(ie2_cnt - ie2_base), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
